// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between the stack controller (r0),
// the load/store unit (r1) and the debug loader (r2). One access is granted
// per cycle: r0 has fixed priority, r1/r2 alternate round-robin. A granted
// access with rK_lock=1 makes K the sole owner until it releases the lock or
// the lock has been held for LOCK_MAX cycles (forced release, sticky
// lock_err, owner barred from relocking until it drops rK_lock). Read data
// is steered back to the requesting port RD_LAT cycles after the grant.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   rK_req/lock/wr     request, hold-ownership, write select (K = 0..2)
//   rK_addr/wdata      byte address and write data
//   rK_gnt             access accepted this cycle (combinational)
//   rK_rvalid          read data for requester K is on rdata
//   rdata              shared read-data return (0 when no rvalid)
//   mem_en/wr/addr/wdata  memory macro strobe and request fields
//   mem_rdata          memory read data, RD_LAT cycles after a read strobe
//   owner              current lock owner, 3 = none
//   lock_err           sticky, set by a forced lock release
module dmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_wr,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_wr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  input  logic          r2_req,
  input  logic          r2_lock,
  input  logic          r2_wr,
  input  logic [AW-1:0] r2_addr,
  input  logic [DW-1:0] r2_wdata,
  output logic          r2_gnt,
  output logic          r2_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic          lock_err
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  logic [2:0]    req, lk, wr;
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];

  assign req      = {r2_req,  r1_req,  r0_req};
  assign lk       = {r2_lock, r1_lock, r0_lock};
  assign wr       = {r2_wr,   r1_wr,   r0_wr};
  assign addr[0]  = r0_addr;
  assign addr[1]  = r1_addr;
  assign addr[2]  = r2_addr;
  assign wdata[0] = r0_wdata;
  assign wdata[1] = r1_wdata;
  assign wdata[2] = r2_wdata;

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          rr_q, rr_d;        // 0: r1 wins a tie, 1: r2 wins a tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          bar_q, bar_d;
  logic [1:0]    bar_id_q, bar_id_d;

  logic [2:0]    gnt;
  logic [2:0]    eff_lk;
  logic          own_req, own_lk, bar_lk;
  logic [1:0]    gid;

  // Arbitration, lock tracking and next-state.
  always_comb begin
    gnt      = '0;
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    bar_d    = bar_q;
    bar_id_d = bar_id_q;
    own_req  = 1'b0;
    own_lk   = 1'b0;
    bar_lk   = 1'b0;
    eff_lk   = '0;

    for (int unsigned k = 0; k < 3; k++) begin
      if (owner_q == 2'(k)) begin
        own_req = req[k];
        own_lk  = lk[k];
      end
      if (bar_id_q == 2'(k)) bar_lk = lk[k];
      // a barred requester may be granted but cannot take the lock
      eff_lk[k] = lk[k] & ~(bar_q & (bar_id_q == 2'(k)));
    end

    if (bar_q && !bar_lk) bar_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req[0])                           gnt[0] = 1'b1;
        else if (req[1] && (!req[2] || !rr_q)) gnt[1] = 1'b1;
        else if (req[2])                      gnt[2] = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
          if (gnt[k] && eff_lk[k]) begin
            state_d = S_LOCKED;
            owner_d = 2'(k);
          end
        end
      end
      S_LOCKED: begin
        for (int unsigned k = 0; k < 3; k++) begin
          if (owner_q == 2'(k)) gnt[k] = own_req;
        end
        cnt_d = cnt_q + CW'(1);
        if (!own_lk) begin
          state_d = S_IDLE;
          owner_d = 2'd3;
        end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
          state_d  = S_IDLE;
          owner_d  = 2'd3;
          err_d    = 1'b1;
          bar_d    = 1'b1;
          bar_id_d = owner_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = 2'd3;
      end
    endcase

    if (gnt[1])      rr_d = 1'b1;
    else if (gnt[2]) rr_d = 1'b0;

    // next-state values are irrelevant under reset; only the strobes matter
    if (reset) gnt = '0;
  end

  // Memory request mux.
  always_comb begin
    mem_en    = |gnt;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    gid       = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (gnt[k]) begin
        mem_wr    = wr[k];
        mem_addr  = addr[k];
        mem_wdata = wdata[k];
        gid       = 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 2'd3;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      bar_q    <= 1'b0;
      bar_id_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      bar_q    <= bar_d;
      bar_id_q <= bar_id_d;
    end
  end

  // Read-return tracker: one {valid, id} slot per cycle of memory latency.
  logic       pv_q  [RD_LAT];
  logic [1:0] pid_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pv_q[i]  <= 1'b0;
        pid_q[i] <= '0;
      end
    end else begin
      pv_q[0]  <= mem_en & ~mem_wr;
      pid_q[0] <= gid;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  logic rv;
  assign rv        = pv_q[RD_LAT-1] & ~reset;
  assign r0_rvalid = rv & (pid_q[RD_LAT-1] == 2'd0);
  assign r1_rvalid = rv & (pid_q[RD_LAT-1] == 2'd1);
  assign r2_rvalid = rv & (pid_q[RD_LAT-1] == 2'd2);
  assign rdata     = rv ? mem_rdata : '0;

  assign r0_gnt   = gnt[0];
  assign r1_gnt   = gnt[1];
  assign r2_gnt   = gnt[2];
  assign owner    = reset ? 2'd3 : owner_q;
  assign lock_err = err_q & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share one
// set of request inputs, each with its own memory macro model. A reference
// model predicts grants, memory bus, owner, lock_err and read returns; a
// negedge monitor compares against queued expectations.
module tb_dmem_arbiter;
  localparam int AW       = 16;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req   [3];
  logic          lock  [3];
  logic          wr    [3];
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];

  logic          gnt    [2][3];
  logic          rv     [2][3];
  logic [DW-1:0] rdata  [2];
  logic          men    [2];
  logic          mwr    [2];
  logic [AW-1:0] maddr  [2];
  logic [DW-1:0] mwdata [2];
  logic [DW-1:0] mrdata [2];
  logic [1:0]    own    [2];
  logic          lerr   [2];

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .LOCK_MAX(LOCK_MAX)) u_lat1 (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_lock(lock[0]), .r0_wr(wr[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt[0][0]), .r0_rvalid(rv[0][0]),
    .r1_req(req[1]), .r1_lock(lock[1]), .r1_wr(wr[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt[0][1]), .r1_rvalid(rv[0][1]),
    .r2_req(req[2]), .r2_lock(lock[2]), .r2_wr(wr[2]), .r2_addr(addr[2]), .r2_wdata(wdata[2]),
    .r2_gnt(gnt[0][2]), .r2_rvalid(rv[0][2]),
    .rdata(rdata[0]), .mem_en(men[0]), .mem_wr(mwr[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]), .owner(own[0]), .lock_err(lerr[0])
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .LOCK_MAX(LOCK_MAX)) u_lat3 (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_lock(lock[0]), .r0_wr(wr[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt[1][0]), .r0_rvalid(rv[1][0]),
    .r1_req(req[1]), .r1_lock(lock[1]), .r1_wr(wr[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt[1][1]), .r1_rvalid(rv[1][1]),
    .r2_req(req[2]), .r2_lock(lock[2]), .r2_wr(wr[2]), .r2_addr(addr[2]), .r2_wdata(wdata[2]),
    .r2_gnt(gnt[1][2]), .r2_rvalid(rv[1][2]),
    .rdata(rdata[1]), .mem_en(men[1]), .mem_wr(mwr[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]), .owner(own[1]), .lock_err(lerr[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    return {a, ~a} ^ 32'h5A3C_0F96;
  endfunction

  // Memory macro models (contents survive DUT reset).
  bit [DW-1:0] macro [2][65536];
  bit          mflag [2][65536];
  bit [DW-1:0] dl    [2][3];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 2; s > 0; s--) dl[i][s] <= dl[i][s-1];
      if (men[i] === 1'b1 && mwr[i] === 1'b0)
        dl[i][0] <= mflag[i][maddr[i]] ? macro[i][maddr[i]] : pre(maddr[i]);
      else
        dl[i][0] <= 32'hDEAD_BEEF;
      if (men[i] === 1'b1 && mwr[i] === 1'b1) begin
        macro[i][maddr[i]] <= mwdata[i];
        mflag[i][maddr[i]] <= 1'b1;
      end
    end
  end
  assign mrdata[0] = dl[0][0];
  assign mrdata[1] = dl[1][2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard queues.
  typedef struct {
    logic [2:0]    gnt;
    logic          en;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    own;
    logic          err;
  } cyc_exp_t;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] d;
  } rd_exp_t;

  cyc_exp_t cq [$];
  rd_exp_t  rq [2][$];

  // Reference model state.
  bit          m_locked = 1'b0;
  int          m_own    = 3;
  int          m_cnt    = 0;
  int          m_rr     = 1;
  bit          m_err    = 1'b0;
  int          m_bar    = -1;
  bit [DW-1:0] refm [65536];
  bit          refw [65536];

  // Model one cycle using the inputs currently applied, then advance a clock.
  task automatic step();
    int       g;
    int       old_bar;
    cyc_exp_t e;
    rd_exp_t  r;
    g = -1;
    if (!reset) begin
      if (m_locked) begin
        if (req[m_own]) g = m_own;
      end else if (req[0]) g = 0;
      else if (req[1] && req[2]) g = m_rr;
      else if (req[1]) g = 1;
      else if (req[2]) g = 2;
    end
    e.gnt = '0; e.en = 1'b0; e.wr = 1'b0; e.a = '0; e.d = '0;
    e.own = (reset || !m_locked) ? 2'd3 : 2'(m_own);
    e.err = m_err && !reset;
    if (g >= 0) begin
      e.gnt[g] = 1'b1;
      e.en     = 1'b1;
      e.wr     = wr[g];
      e.a      = addr[g];
      e.d      = wdata[g];
      if (wr[g]) begin
        refm[addr[g]] = wdata[g];
        refw[addr[g]] = 1'b1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          r.due = cyc + lat(i);
          r.id  = g;
          r.d   = refw[addr[g]] ? refm[addr[g]] : pre(addr[g]);
          rq[i].push_back(r);
        end
      end
    end
    cq.push_back(e);

    if (reset) begin
      m_locked = 1'b0; m_own = 3; m_cnt = 0; m_rr = 1; m_err = 1'b0; m_bar = -1;
      rq[0].delete();
      rq[1].delete();
    end else begin
      if (g == 1) m_rr = 2;
      else if (g == 2) m_rr = 1;
      old_bar = m_bar;
      if (m_bar >= 0 && !lock[m_bar]) m_bar = -1;
      if (!m_locked) begin
        if (g >= 0 && lock[g] && old_bar != g) begin
          m_locked = 1'b1; m_own = g; m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (!lock[m_own]) begin
          m_locked = 1'b0; m_own = 3;
        end else if (m_cnt == LOCK_MAX) begin
          m_err = 1'b1; m_bar = m_own; m_locked = 1'b0; m_own = 3;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUTs present against queued expectations.
  cyc_exp_t   me;
  rd_exp_t    mr;
  logic [2:0] rvv;

  always @(negedge clk) begin
    if (cq.size() > 0) begin
      me = cq.pop_front();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("gnt_lat%0d", lat(i)), {gnt[i][2], gnt[i][1], gnt[i][0]}, me.gnt);
        chk($sformatf("membus_lat%0d", lat(i)), {men[i], mwr[i], maddr[i], mwdata[i]},
            {me.en, me.wr, me.a, me.d});
        chk($sformatf("owner_lat%0d", lat(i)), own[i], me.own);
        chk($sformatf("lock_err_lat%0d", lat(i)), lerr[i], me.err);
      end
    end
    for (int i = 0; i < 2; i++) begin
      rvv = {rv[i][2], rv[i][1], rv[i][0]};
      if (rvv == 3'b000) begin
        chk($sformatf("rdata_idle_lat%0d", lat(i)), rdata[i], '0);
        if (rq[i].size() > 0 && rq[i][0].due <= cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL rvalid_missing_lat%0d at cycle %0d: got none expected id %0d",
                   lat(i), cyc, rq[i][0].id);
          void'(rq[i].pop_front());
        end
      end else if (rq[i].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rvalid_unexpected_lat%0d at cycle %0d: got %b expected none",
                 lat(i), cyc, rvv);
      end else begin
        mr = rq[i].pop_front();
        chk($sformatf("rvalid_id_lat%0d", lat(i)), rvv, 3'b001 << mr.id);
        chk($sformatf("rdata_lat%0d", lat(i)), rdata[i], mr.d);
        chk($sformatf("rvalid_cycle_lat%0d", lat(i)), cyc, mr.due);
      end
    end
  end

  task automatic clear_in();
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; lock[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
  endtask

  task automatic put(input int k, input bit l, input bit w, input logic [AW-1:0] a);
    req[k] = 1'b1; lock[k] = l; wr[k] = w; addr[k] = a; wdata[k] = $urandom;
  endtask

  logic [AW-1:0] pool [8] = '{16'h0010, 16'h0020, 16'h0030, 16'hFFF4,
                              16'hFFF8, 16'hFFFC, 16'h0100, 16'h0104};

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    // reset with live requests: nothing may be granted
    put(0, 1, 0, 16'h0010); put(1, 1, 1, 16'h0020);
    step();
    step();
    reset = 1'b0;

    // priority and round-robin
    for (int t = 0; t < 4; t++) begin
      clear_in();
      if (t == 0) put(0, 0, 0, 16'h0010);
      put(1, 0, 0, 16'h0020);
      put(2, 0, 0, 16'h0030);
      step();
    end
    clear_in();
    repeat (3) step();

    // locked burst of writes from r0 while r1 waits
    for (int t = 0; t < 5; t++) begin
      clear_in();
      if (t < 3) put(0, t < 2, 1, 16'(16'hFFFC - 4 * t));
      put(1, 0, 0, 16'h0100);
      step();
    end
    for (int t = 0; t < 3; t++) begin
      clear_in();
      put(2, 0, 0, 16'(16'hFFFC - 4 * t));
      step();
    end

    // bubble inside a lock
    for (int t = 0; t < 5; t++) begin
      clear_in();
      if (t == 0) put(0, 1, 0, 16'h0010);
      if (t == 1 || t == 2) lock[0] = 1'b1;
      if (t == 3) put(0, 0, 0, 16'h0010);
      put(2, 0, 0, 16'h0030);
      step();
    end
    clear_in();
    repeat (3) step();

    // forced release after LOCK_MAX locked cycles, then relock bar
    for (int t = 0; t < 23; t++) begin
      clear_in();
      put(1, (t < 20) || (t == 21), 0, 16'h0020);
      if (t > 0 && t < 21) put(2, 0, 0, 16'h0030);
      step();
    end
    clear_in();
    repeat (3) step();

    // latency sweep: r1, r2, r0 on consecutive cycles
    for (int t = 0; t < 3; t++) begin
      clear_in();
      put((t + 1) % 3, 0, 0, pool[t + 3]);
      step();
    end
    clear_in();
    repeat (4) step();

    // reset while r0 holds a lock with reads in flight
    clear_in(); put(0, 1, 0, 16'h0104); step();
    clear_in(); put(0, 1, 0, 16'h0010); step();
    clear_in(); reset = 1'b1; put(0, 1, 0, 16'h0010); put(1, 0, 0, 16'h0020); step();
    clear_in(); reset = 1'b0; put(1, 0, 0, 16'h0020); put(2, 0, 0, 16'h0030); step();
    clear_in();
    repeat (4) step();

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      clear_in();
      reset = ($urandom_range(149) == 0);
      for (int k = 0; k < 3; k++) begin
        req[k]   = (k == 0) ? ($urandom_range(2) == 0) : ($urandom_range(2) != 0);
        lock[k]  = ($urandom_range(7) != 0);
        wr[k]    = 1'($urandom_range(1));
        addr[k]  = pool[$urandom_range(7)];
        wdata[k] = $urandom;
      end
      step();
    end
    reset = 1'b0;
    clear_in();
    repeat (6) step();
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("rd_queue_drained_lat%0d", lat(i)), rq[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter for the CPU core: it shares one 32-bit data memory between the stack controller (PUSH/POP bursts), the load/store unit and the debug loader. It sits between those requesters and the data memory macro. It grants one access per cycle, honours a lock that keeps multi-word bursts atomic, and returns read data to the correct requester after the fixed memory latency.

## Interface
Parameters:
- AW, 16, address width
- DW, 32, data width
- RD_LAT, 1, memory read latency in cycles (1..3)
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rK_req  in  1  access request, K=0 (stack ctrl), 1 (load/store), 2 (debug)
- rK_lock  in  1  hold ownership after this access
- rK_wr  in  1  1=write, 0=read
- rK_addr  in  AW  byte address
- rK_wdata  in  DW  write data
- rK_gnt  out  1  access accepted this cycle (combinational)
- rK_rvalid  out  1  read data for requester K valid on rdata
- rdata  out  DW  shared read-data return
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_en with mem_wr=0
- owner  out  2  current lock owner; 3 = none
- lock_err  out  1  sticky; set on forced lock release

## Operation
- States: IDLE (no lock) and LOCKED (owner holds the memory).
- IDLE arbitration: r0 has fixed highest priority. r1 and r2 share round-robin through pointer rr. After reset rr favours r1. rr flips to the other requester whenever r1 or r2 is granted.
- At most one rK_gnt is high per cycle. mem_en equals the OR of all grants. mem_wr, mem_addr and mem_wdata are muxed from the granted requester and are 0 when nothing is granted.
- A grant with rK_lock=1 moves the block to LOCKED with owner=K on the next cycle.
- LOCKED:
  - Only the owner can be granted. Other requests stall with gnt=0.
  - If the owner has req=0, the cycle is an idle bubble and the lock is kept.
  - An owner access with lock=0 is granted, and the state returns to IDLE next cycle.
  - An owner cycle with req=0 and lock=0 returns the block to IDLE without an access.
- Lock counter:
  - Counts cycles spent in LOCKED.
  - When it reaches LOCK_MAX, the state is forced to IDLE next cycle, lock_err is set, and the owner is barred from relocking.
  - The bar clears once the owner samples rK_lock=0.
  - While barred, the owner may still be granted, but its lock is ignored.
- Read return: each granted read pushes {valid, id} into an RD_LAT-deep shift register. On exit, rK_rvalid is asserted for the matching id and rdata = mem_rdata. Writes push valid=0.
- rdata holds 0 when no rvalid is asserted.

## Timing
- Grant and memory strobe are combinational in the request cycle. Read data returns exactly RD_LAT cycles later.
- Back-to-back reads from any mix of requesters are supported with one read per cycle and no bubbles.
- On reset:
  - every rK_gnt, rK_rvalid, mem_en, mem_wr and lock_err is 0;
  - mem_addr, mem_wdata and rdata are 0;
  - owner=3, state IDLE, rr→r1, lock counter 0;
  - in-flight reads are discarded and never produce rvalid.
- Reset asserted mid-lock releases the lock immediately. The first post-reset cycle arbitrates from IDLE.
- If a requester's lock rises in the same cycle as a higher-priority request, the higher-priority request wins and no lock is taken.
- Lock counter width is clog2(LOCK_MAX+1). It does not wrap and saturates at forced release.

## Test plan
- Priority and round-robin: r0, r1 and r2 all request reads for 4 cycles from reset, r0 drops after cycle 1. Required: grants r0, r1, r2, r1. rK_rvalid follows with RD_LAT=1, and each requester's rdata equals the value preloaded at its address.
- Locked burst: r0 pushes 3 words at 0xFFFC, 0xFFF8, 0xFFF4 with lock=1, 1, 0 while r1 requests continuously. Required: r1_gnt=0 for those 3 cycles, r1 is granted in cycle 4, and owner shows 0 then 3.
- Bubble in lock: r0 locks, then holds req=0 and lock=1 for 2 cycles while r2 requests. Required: mem_en=0 and r2_gnt=0 during the bubble, and the lock persists.
- Forced release: r1 holds lock=1 for 20 cycles with LOCK_MAX=16. Required: the forced release occurs on cycle 17 (LOCKED→IDLE), lock_err=1 and stays set, and r2 is granted on the next cycle. r1's relock is ignored until r1_lock goes low.
- Latency sweep: with RD_LAT=3, reads from r1, r2 and r0 on consecutive cycles. Required: rvalids appear in the same order, 3 cycles after each grant, one per cycle.
- Reset mid-burst: reset asserted while r0 is locked and 2 reads are in flight. Required: every rK_rvalid stays 0 afterwards, owner=3, and r1 is granted on the first cycle after reset.
